// File: rtl/fm_demod_mc_if.sv
// Sample-stream bus for the multi-channel FM demodulator.
// Handshake: the input side is a first-word-fall-through FIFO. in_re/in_im/in_ch
// are valid whenever in_empty is low, and the sample is consumed on the clock
// edge that ends the cycle in which in_rd_en is high. The output side pushes
// out_data/out_ch on the clock edge that ends a cycle with out_wr_en high. The
// demodulator raises out_wr_en only after it has seen out_full low.
interface fm_demod_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_W       = 1
);
    logic signed [DATA_WIDTH-1:0] in_re;
    logic signed [DATA_WIDTH-1:0] in_im;
    logic [CH_W-1:0]              in_ch;
    logic                         in_empty;
    logic                         in_rd_en;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_full;
    logic                         out_wr_en;
    logic [2:0]                   dbg_state;

    // Environment side: the FIFOs around the demodulator.
    modport master (
        output in_re, in_im, in_ch, in_empty, out_full,
        input  in_rd_en, out_data, out_ch, out_wr_en, dbg_state
    );

    // Demodulator side.
    modport slave (
        input  in_re, in_im, in_ch, in_empty, out_full,
        output in_rd_en, out_data, out_ch, out_wr_en, dbg_state
    );
endinterface

// File: rtl/fm_demod_mc.sv
// Multi-channel FM demodulator. Per channel it forms the conjugate product of
// the current and previous I/Q sample, estimates the phase step with an
// arctan approximation built on an iterative divider, and scales the result
// by GAIN. Each sample takes DATA_WIDTH+4 cycles from pop to the next pop.
module fm_demod_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int NUM_CH     = 2,
    parameter int GAIN       = 758,
    parameter int QUAD1      = 804,
    parameter int QUAD3      = 2412
) (
    input  logic         clk,
    input  logic         rst,
    fm_demod_mc_if.slave bus,
    input  logic         clear_hist,
    output logic         busy,
    output logic         ch_err
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic signed [PW-1:0]         L_GAIN    = PW'(GAIN);
    localparam logic signed [PW-1:0]         L_QUAD1   = PW'(QUAD1);
    localparam logic signed [DATA_WIDTH-1:0] L_QUAD1_D = DATA_WIDTH'(QUAD1);
    localparam logic signed [DATA_WIDTH-1:0] L_QUAD3_D = DATA_WIDTH'(QUAD3);
    localparam logic signed [DATA_WIDTH-1:0] L_ONE     = DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        S_READ   = 3'd0,
        S_RUN    = 3'd1,
        S_DIVIDE = 3'd2,
        S_ANGLE  = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    state_t                       r_state;
    logic                         r_rd_en;
    logic                         r_wr_en;
    logic                         r_ch_err;
    logic                         r_first;
    logic                         r_neg;
    logic [CH_W-1:0]              r_ch;
    logic [CH_W-1:0]              r_out_ch;
    logic signed [DATA_WIDTH-1:0] r_r;
    logic signed [DATA_WIDTH-1:0] r_i;
    logic signed [DATA_WIDTH-1:0] r_angle;
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0]        r_quo;
    logic [DATA_WIDTH-1:0]        r_rem;
    logic [DATA_WIDTH-1:0]        r_dsr;
    logic [CNT_W-1:0]             r_cnt;
    logic signed [DATA_WIDTH-1:0] r_hist_re [NUM_CH];
    logic signed [DATA_WIDTH-1:0] r_hist_im [NUM_CH];
    logic [NUM_CH-1:0]            r_hist_valid;

    // Input acceptance. r_rd_en blocks a second look at a word the FIFO has
    // not yet dropped, which matters when a bad-channel sample keeps us in READ.
    logic [31:0] w_ch_ext;
    logic        w_ch_ok;
    logic        w_accept;
    assign w_ch_ext = 32'(bus.in_ch);
    assign w_ch_ok  = (w_ch_ext < 32'(NUM_CH));
    assign w_accept = (r_state == S_READ) && !bus.in_empty && !r_rd_en;

    // Conjugate product of the new sample with the channel's previous one.
    logic signed [DATA_WIDTH-1:0] w_p_re, w_p_im, w_r_new, w_i_new;
    logic signed [PW-1:0]         w_pre, w_pim, w_xre, w_xim, w_r_full, w_i_full;
    assign w_p_re   = r_hist_re[bus.in_ch];
    assign w_p_im   = r_hist_im[bus.in_ch];
    assign w_pre    = PW'(w_p_re);
    assign w_pim    = PW'(w_p_im);
    assign w_xre    = PW'(bus.in_re);
    assign w_xim    = PW'(bus.in_im);
    assign w_r_full = w_pre * w_xre + w_pim * w_xim;
    assign w_i_full = w_pre * w_xim - w_pim * w_xre;
    assign w_r_new  = DATA_WIDTH'(w_r_full >>> FRAC_BITS);
    assign w_i_new  = DATA_WIDTH'(w_i_full >>> FRAC_BITS);

    // Divider operands; the +1 on |i| keeps the divisor at least 1.
    logic signed [DATA_WIDTH-1:0] w_i_abs, w_dividend, w_divisor;
    assign w_i_abs    = (r_i[DATA_WIDTH-1] ? -r_i : r_i) + L_ONE;
    assign w_dividend = r_r[DATA_WIDTH-1] ? ((r_r + w_i_abs) <<< FRAC_BITS)
                                          : ((r_r - w_i_abs) <<< FRAC_BITS);
    assign w_divisor  = r_r[DATA_WIDTH-1] ? (w_i_abs - r_r) : (r_r + w_i_abs);

    // One restoring step on magnitudes; the sign is reapplied afterwards,
    // which gives truncation toward zero.
    logic [DATA_WIDTH:0]   w_rem_sh;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_rem_nx;
    assign w_rem_sh = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dsr});
    assign w_rem_nx = w_ge ? DATA_WIDTH'(w_rem_sh - {1'b0, r_dsr}) : DATA_WIDTH'(w_rem_sh);

    // Arctan approximation from the quotient, then output scaling.
    logic signed [DATA_WIDTH-1:0] w_q, w_imm, w_ang_base, w_angle, w_out_val;
    logic signed [PW-1:0]         w_q_ext, w_ang_ext;
    assign w_q        = r_neg ? -$signed(r_quo) : $signed(r_quo);
    assign w_q_ext    = PW'(w_q);
    assign w_imm      = DATA_WIDTH'((w_q_ext * L_QUAD1) >>> FRAC_BITS);
    assign w_ang_base = r_r[DATA_WIDTH-1] ? (L_QUAD3_D - w_imm) : (L_QUAD1_D - w_imm);
    assign w_angle    = r_i[DATA_WIDTH-1] ? -w_ang_base : w_ang_base;
    assign w_ang_ext  = PW'(r_angle);
    assign w_out_val  = DATA_WIDTH'((w_ang_ext * L_GAIN) >>> FRAC_BITS);

    // Per-channel history; a clear overrides a store in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_hist_re[k] <= '0;
                r_hist_im[k] <= '0;
            end
            r_hist_valid <= '0;
        end else if (clear_hist) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_hist_re[k] <= '0;
                r_hist_im[k] <= '0;
            end
            r_hist_valid <= '0;
        end else if (w_accept && w_ch_ok) begin
            r_hist_re[bus.in_ch]    <= bus.in_re;
            r_hist_im[bus.in_ch]    <= bus.in_im;
            r_hist_valid[bus.in_ch] <= 1'b1;
        end
    end

    // Control FSM with the divider datapath and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_READ;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_ch_err   <= 1'b0;
            r_first    <= 1'b0;
            r_neg      <= 1'b0;
            r_ch       <= '0;
            r_out_ch   <= '0;
            r_r        <= '0;
            r_i        <= '0;
            r_angle    <= '0;
            r_out_data <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dsr      <= '0;
            r_cnt      <= '0;
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                S_READ: begin
                    if (w_accept) begin
                        r_rd_en <= 1'b1;
                        if (w_ch_ok) begin
                            r_ch    <= bus.in_ch;
                            r_r     <= w_r_new;
                            r_i     <= w_i_new;
                            r_first <= !r_hist_valid[bus.in_ch];
                            r_state <= S_RUN;
                        end else begin
                            r_ch_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_neg   <= w_dividend[DATA_WIDTH-1];
                    r_quo   <= w_dividend[DATA_WIDTH-1] ? DATA_WIDTH'(-w_dividend)
                                                        : DATA_WIDTH'(w_dividend);
                    r_rem   <= '0;
                    r_dsr   <= DATA_WIDTH'(w_divisor);
                    r_cnt   <= '0;
                    r_state <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_nx;
                    r_quo <= {r_quo[DATA_WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        r_state <= S_ANGLE;
                    end
                end
                S_ANGLE: begin
                    r_angle <= w_angle;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (!bus.out_full) begin
                        r_wr_en    <= 1'b1;
                        r_out_data <= r_first ? '0 : w_out_val;
                        r_out_ch   <= r_ch;
                        r_state    <= S_READ;
                    end
                end
                default: r_state <= S_READ;
            endcase
        end
    end

    assign bus.in_rd_en  = r_rd_en;
    assign bus.out_wr_en = r_wr_en;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.dbg_state = r_state;
    assign busy          = (r_state != S_READ);
    assign ch_err        = r_ch_err;
endmodule

// File: tb/tb_fm_demod_mc.sv
// Directed bench for fm_demod_mc with three channels (so an out-of-range tag
// exists) at DATA_WIDTH=32, FRAC_BITS=10. Expected outputs are hand-computed.
module tb_fm_demod_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_hist = 1'b0;
    logic busy;
    logic ch_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int pushes = 0;
    int pop_cyc = 0;
    int push_cyc = 0;
    logic signed [31:0] push_data = '0;
    logic [1:0]         push_ch = '0;

    // Clock.
    always #5 clk = ~clk;

    fm_demod_mc_if #(.DATA_WIDTH(32), .CH_W(2)) bus ();

    fm_demod_mc #(
        .DATA_WIDTH(32),
        .FRAC_BITS (10),
        .NUM_CH    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clear_hist(clear_hist),
        .busy      (busy),
        .ch_err    (ch_err)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance to the next falling edge and log pops/pushes seen there.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.in_rd_en) begin
            pops++;
            pop_cyc = cyc;
        end
        if (bus.out_wr_en) begin
            pushes++;
            push_cyc  = cyc;
            push_data = bus.out_data;
            push_ch   = bus.out_ch;
        end
    endtask

    task automatic start_send(input logic signed [31:0] re, input logic signed [31:0] im,
                              input logic [1:0] ch);
        bus.in_re    = re;
        bus.in_im    = im;
        bus.in_ch    = ch;
        bus.in_empty = 1'b0;
    endtask

    task automatic finish_send(input string tag);
        int n = 0;
        while (!bus.in_rd_en && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_pop"}, bus.in_rd_en, 1);
        bus.in_empty = 1'b1;
    endtask

    task automatic send(input string tag, input logic signed [31:0] re,
                        input logic signed [31:0] im, input logic [1:0] ch);
        start_send(re, im, ch);
        finish_send(tag);
    endtask

    task automatic expect_out(input string tag, input logic signed [31:0] exp_d,
                              input logic [1:0] exp_ch);
        int s0 = pushes;
        int n = 0;
        while (pushes == s0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_push"}, pushes - s0, 1);
        check({tag, "_data"}, push_data, exp_d);
        check({tag, "_ch"}, push_ch, exp_ch);
    endtask

    task automatic pulse_clear();
        clear_hist = 1'b1;
        tick();
        clear_hist = 1'b0;
    endtask

    initial begin
        int n;
        int s0;
        int p0;
        int viol;

        bus.in_re    = '0;
        bus.in_im    = '0;
        bus.in_ch    = '0;
        bus.in_empty = 1'b1;
        bus.out_full = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_rd_en", bus.in_rd_en, 0);
        check("rst_wr_en", bus.out_wr_en, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_ch", bus.out_ch, 0);
        check("rst_busy", busy, 0);
        check("rst_ch_err", ch_err, 0);
        check("rst_state", bus.dbg_state, 0);
        rst = 1'b0;
        tick();

        // Same sample twice on ch0: first output 0, then angle 2 -> 1.
        send("s1", 32'sd1024, 32'sd0, 2'd0);
        check("busy_run", busy, 1);
        expect_out("s1", 32'sd0, 2'd0);
        send("s2", 32'sd1024, 32'sd0, 2'd0);
        expect_out("s2", 32'sd1, 2'd0);
        check("latency", push_cyc - pop_cyc, 35);
        check("idle_busy", busy, 0);

        // Quarter-turn steps in both directions, channels back to back.
        pulse_clear();
        send("a0", 32'sd1024, 32'sd0, 2'd0);
        expect_out("a0", 32'sd0, 2'd0);
        send("a1", 32'sd0, 32'sd1024, 2'd0);
        expect_out("a1", 32'sd1190, 2'd0);
        send("b0", 32'sd1024, 32'sd0, 2'd1);
        expect_out("b0", 32'sd0, 2'd1);
        send("b1", 32'sd0, -32'sd1024, 2'd1);
        expect_out("b1", -32'sd1191, 2'd1);

        // Same samples interleaved across channels.
        pulse_clear();
        send("i0", 32'sd1024, 32'sd0, 2'd0);
        expect_out("i0", 32'sd0, 2'd0);
        send("i1", 32'sd1024, 32'sd0, 2'd1);
        expect_out("i1", 32'sd0, 2'd1);
        send("i2", 32'sd0, 32'sd1024, 2'd0);
        expect_out("i2", 32'sd1190, 2'd0);
        send("i3", 32'sd0, -32'sd1024, 2'd1);
        expect_out("i3", -32'sd1191, 2'd1);

        // Backpressure at WRITE with another sample waiting in the FIFO.
        bus.out_full = 1'b1;
        send("bp", 32'sd0, -32'sd1024, 2'd0);
        n = 0;
        while (bus.dbg_state != 3'd4 && n < 200) begin
            tick();
            n++;
        end
        check("bp_at_write", bus.dbg_state, 4);
        start_send(32'sd1024, 32'sd0, 2'd1);
        p0 = pops;
        s0 = pushes;
        viol = 0;
        repeat (20) begin
            tick();
            if (bus.out_wr_en || bus.in_rd_en || bus.out_data !== -32'sd1191 || bus.out_ch !== 2'd1)
                viol++;
        end
        check("bp_hold_stable", viol, 0);
        check("bp_no_pop", pops - p0, 0);
        check("bp_no_push", pushes - s0, 0);
        bus.out_full = 1'b0;
        expect_out("bp_release", 32'sd2379, 2'd0);
        finish_send("bp_pending");
        check("bp_one_push", pushes - s0, 1);
        expect_out("bp_pending", 32'sd1190, 2'd1);

        // Out-of-range channel: popped, flagged, nothing written.
        p0 = pops;
        send("bad", 32'sd1024, 32'sd0, 2'd3);
        s0 = pushes;
        repeat (50) tick();
        check("bad_one_pop", pops - p0, 1);
        check("bad_no_push", pushes - s0, 0);
        check("bad_ch_err", ch_err, 1);
        check("bad_busy", busy, 0);

        // History clear between samples, then clear coinciding with a pop.
        pulse_clear();
        send("clr", 32'sd1024, 32'sd0, 2'd0);
        expect_out("clr", 32'sd0, 2'd0);
        start_send(32'sd1024, 32'sd0, 2'd2);
        clear_hist = 1'b1;
        finish_send("simul");
        clear_hist = 1'b0;
        expect_out("simul", 32'sd0, 2'd2);
        send("simul_next", 32'sd1024, 32'sd0, 2'd2);
        expect_out("simul_next", 32'sd0, 2'd2);
        check("ch_err_sticky", ch_err, 1);

        // Reset while dividing: sample abandoned, everything back to zero.
        send("rd", 32'sd1024, 32'sd0, 2'd0);
        repeat (10) tick();
        check("rd_in_divide", bus.dbg_state, 2);
        s0 = pushes;
        rst = 1'b1;
        tick();
        check("rd_rd_en", bus.in_rd_en, 0);
        check("rd_wr_en", bus.out_wr_en, 0);
        check("rd_data", bus.out_data, 0);
        check("rd_ch", bus.out_ch, 0);
        check("rd_busy", busy, 0);
        check("rd_ch_err", ch_err, 0);
        check("rd_state", bus.dbg_state, 0);
        rst = 1'b0;
        repeat (60) tick();
        check("rd_no_push", pushes - s0, 0);
        send("post", 32'sd1024, 32'sd0, 2'd0);
        expect_out("post", 32'sd0, 2'd0);
        check("post_latency", push_cyc - pop_cyc, 35);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fm_demod_mc.md
FM_DEMOD_MC -- requirements
Module: fm_demod_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: sample, product-result and output width.
REQ-002 SHALL have parameter FRAC_BITS, default 10: fixed-point fraction bits.
REQ-003 SHALL have parameter NUM_CH, default 2: number of interleaved channels; CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have parameters GAIN=758, QUAD1=804, QUAD3=2412: output gain, pi/4 and 3pi/4 in FRAC_BITS format.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset (rst, asynchronous, active-high; clock clk).
REQ-006 SHALL have ports: in_re in DATA_WIDTH signed I; in_im in DATA_WIDTH signed Q; in_ch in CH_W channel tag.
REQ-007 SHALL have ports: in_empty in 1 input-FIFO empty; in_rd_en out 1 FWFT pop, data valid same cycle.
REQ-008 SHALL have ports: out_data out DATA_WIDTH signed demod sample; out_ch out CH_W tag; out_full in 1 output-FIFO full; out_wr_en out 1 push.
REQ-009 SHALL have ports: clear_hist in 1 history clear; busy out 1 high outside READ; ch_err out 1 sticky bad-channel flag.

Function
REQ-010 SHALL implement FSM states READ, RUN, DIVIDE, ANGLE, WRITE.
REQ-011 READ: when in_empty=0, SHALL pulse in_rd_en for one cycle, register ch, and go to RUN; otherwise stay.
REQ-012 READ with in_ch >= NUM_CH: sample popped, ch_err set, no output, no history update, stay in READ.
REQ-013 READ with valid in_ch: SHALL register r = (p_re*re + p_im*im)>>>FRAC_BITS and i = (p_re*im - p_im*re)>>>FRAC_BITS, where p = channel history; products full 2*DATA_WIDTH signed, result truncated to DATA_WIDTH.
REQ-014 READ: SHALL store (re,im) as that channel's history and set its hist_valid; a per-channel first flag is latched = !hist_valid.
REQ-015 RUN: i_abs = |i|+1; r>=0: dividend = (r-i_abs)<<FRAC_BITS, divisor = r+i_abs; else dividend = (r+i_abs)<<FRAC_BITS, divisor = i_abs-r; start divider.
REQ-016 Divider SHALL be internal, iterative, signed, truncating toward zero, exactly DATA_WIDTH cycles in DIVIDE; divisor >= 1 by construction.
REQ-017 ANGLE: imm = (QUAD1*q)>>>FRAC_BITS; angle = QUAD1-imm if r>=0 else QUAD3-imm; negate angle if i<0.
REQ-018 WRITE: when out_full=0, SHALL pulse out_wr_en with out_data = (GAIN*angle)>>>FRAC_BITS (2*DATA_WIDTH product), or 0 if first flag set, out_ch = ch; return to READ. When out_full=1, hold WRITE with out_data/out_ch stable.
REQ-019 Latency: out_wr_en SHALL assert exactly DATA_WIDTH+3 cycles after in_rd_en when out_full stays 0; throughput one sample per DATA_WIDTH+4 cycles.
REQ-020 out_data and out_ch SHALL be registered and held between writes.
REQ-021 clear_hist SHALL zero all history and hist_valid the next cycle; an in-flight sample completes with its already-latched values; clear_hist and a READ pop in the same cycle: clear wins, popped sample's history is not stored.
REQ-022 ch_err SHALL clear only on rst.
REQ-023 Channels SHALL be fully independent; interleaving order does not affect per-channel results.

Reset
REQ-024 rst SHALL force state READ, in_rd_en=0, out_wr_en=0, out_data=0, out_ch=0, busy=0, ch_err=0, all history and hist_valid=0, divider idle.
REQ-025 rst mid-operation SHALL abandon the in-flight sample with no write.

Verification
REQ-026 After rst, ch0 (1024,0) then ch0 (1024,0) -> outputs 0, then 1 (r=1024, i=0, q=1022, angle=2).
REQ-027 ch0 (1024,0) then ch0 (0,1024) -> 0, then 1190; ch1 (1024,0), (0,-1024) -> 0, then -1191.
REQ-028 Interleave ch0/ch1 samples from REQ-027 -> each channel matches its non-interleaved sequence, out_ch correct.
REQ-029 Hold out_full=1 for 20 cycles at WRITE -> out_wr_en low, out_data stable, exactly one push after release; in_rd_en low meanwhile.
REQ-030 in_ch=NUM_CH -> one pop, no push, ch_err=1 until rst; clear_hist between samples -> next output 0.
REQ-031 Measure in_rd_en to out_wr_en = 35 cycles at DATA_WIDTH=32; assert rst during DIVIDE -> no write, all outputs 0.
